// File: rtl/io_pkg.sv
// Shared constants and types for the basic computer's I/O terminal.
package io_pkg;

  localparam int CHAR_W        = 8;
  localparam int DEF_IN_DEPTH  = 4;
  localparam int DEF_OUT_DELAY = 8;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SEND
  } out_state_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO used as the keyboard character buffer.
// The head entry is visible on dout whenever the FIFO is not empty.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = CHAR_W,
  parameter int DEPTH = DEF_IN_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two; a push and a
  // pop on the same edge leave the occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_terminal.sv
// Device end of the INPR/FGI and OUTR/FGO handshake: a buffered keyboard
// input path and a delayed printer output path, independent of each other.
module io_terminal
  import io_pkg::*;
#(
  parameter int IN_DEPTH  = DEF_IN_DEPTH,
  parameter int OUT_DELAY = DEF_OUT_DELAY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CHAR_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [CHAR_W-1:0] inpr_out,
  output logic              fgi,
  input  logic              inp_exec,
  input  logic [CHAR_W-1:0] outr_in,
  input  logic              out_exec,
  output logic              fgo,
  output logic [CHAR_W-1:0] prn_data,
  output logic              prn_valid,
  input  logic              prn_ready,
  output logic              overrun
);

  localparam int CW = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((OUT_DELAY > 0) ? OUT_DELAY - 1 : 0);

  logic [CHAR_W-1:0]          fifo_head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(IN_DEPTH):0]  fifo_count;
  logic                       unused_fifo_count;
  logic                       load;

  out_state_t                 state, state_n;
  logic [CW-1:0]              cnt, cnt_n;
  logic [CHAR_W-1:0]          prn_data_n;

  assign kbd_ready         = ~fifo_full;
  assign load              = ~fgi & ~fifo_empty;
  assign unused_fifo_count = ^fifo_count;
  assign fgo               = (state == IDLE);
  assign prn_valid         = (state == SEND);

  io_fifo #(
    .WIDTH(CHAR_W),
    .DEPTH(IN_DEPTH)
  ) u_kbd_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (kbd_valid),
    .din    (kbd_data),
    .pop    (load),
    .dout   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // INPR/FGI: load the buffer head whenever the flag is clear, INP clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inpr_out <= '0;
      fgi      <= 1'b0;
    end else if (load) begin
      inpr_out <= fifo_head;
      fgi      <= 1'b1;
    end else if (inp_exec && fgi) begin
      fgi      <= 1'b0;
    end
  end

  // Sticky error flag for INP with nothing to read or OUT while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if ((inp_exec && !fgi) || (out_exec && state != IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // Output FSM state, delay counter and latched printer character.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      prn_data <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      prn_data <= prn_data_n;
    end
  end

  // Next-state logic: OUT latches the char, then delay, then offer to printer.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    prn_data_n = prn_data;
    case (state)
      IDLE: begin
        if (out_exec) begin
          prn_data_n = outr_in;
          if (OUT_DELAY == 0) begin
            state_n = SEND;
          end else begin
            state_n = DELAY;
            cnt_n   = CNT_LOAD;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) state_n = SEND;
        else           cnt_n   = cnt - 1'b1;
      end
      SEND: begin
        if (prn_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_terminal.sv
// Directed self-checking bench for io_terminal (OUT_DELAY=8 and OUT_DELAY=0).
module tb_io_terminal;

  logic       clk;
  logic       reset_n;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic [7:0] outr_in;
  logic       inp_exec;
  logic       out_exec;
  logic       prn_ready;

  logic       kbd_ready, fgi, fgo, prn_valid, overrun;
  logic [7:0] inpr_out, prn_data;

  logic       kbd_ready0, fgi0, fgo0, prn_valid0, overrun0;
  logic [7:0] inpr_out0, prn_data0;

  int compared   = 0;
  int mismatched = 0;

  io_terminal #(.IN_DEPTH(4), .OUT_DELAY(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .inpr_out(inpr_out), .fgi(fgi), .inp_exec(inp_exec),
    .outr_in(outr_in), .out_exec(out_exec), .fgo(fgo),
    .prn_data(prn_data), .prn_valid(prn_valid), .prn_ready(prn_ready),
    .overrun(overrun)
  );

  io_terminal #(.IN_DEPTH(4), .OUT_DELAY(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready0),
    .inpr_out(inpr_out0), .fgi(fgi0), .inp_exec(inp_exec),
    .outr_in(outr_in), .out_exec(out_exec), .fgo(fgo0),
    .prn_data(prn_data0), .prn_valid(prn_valid0), .prn_ready(prn_ready),
    .overrun(overrun0)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; kbd_data = 8'h00; kbd_valid = 1'b0; outr_in = 8'h00;
    inp_exec = 1'b0; out_exec = 1'b0; prn_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (fgo !== 1'b1)      begin mismatched++; $display("[TB] FAIL reset_fgo got %b want 1", fgo); end
    compared++; if (fgi !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_fgi got %b want 0", fgi); end
    compared++; if (kbd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_kbd_ready got %b want 1", kbd_ready); end
    compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_prn_valid got %b want 0", prn_valid); end
    compared++; if (inpr_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_inpr got %h want 00", inpr_out); end
    compared++; if (prn_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_prn_data got %h want 00", prn_data); end
    compared++; if (overrun !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_overrun got %b want 0", overrun); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_input();
    kbd_data = 8'h44; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL single_fgi_after_push got %b want 0", fgi); end
    step();
    compared++; if (fgi !== 1'b1) begin mismatched++; $display("[TB] FAIL single_fgi_after_load got %b want 1", fgi); end
    compared++; if (inpr_out !== 8'h44) begin mismatched++; $display("[TB] FAIL single_inpr got %h want 44", inpr_out); end
    inp_exec = 1'b1;
    step();
    inp_exec = 1'b0;
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL single_fgi_after_inp got %b want 0", fgi); end
    compared++; if (inpr_out !== 8'h44) begin mismatched++; $display("[TB] FAIL single_inpr_hold got %h want 44", inpr_out); end
    step();
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL single_fgi_stays_low got %b want 0", fgi); end
  endtask

  task automatic test_input_burst();
    for (int i = 0; i < 5; i++) begin
      kbd_data = 8'h41 + 8'(i); kbd_valid = 1'b1;
      compared++; if (kbd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_ready_%0d got %b want 1", i, kbd_ready); end
      step();
    end
    kbd_data = 8'h46;
    compared++; if (kbd_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL burst_full got %b want 0", kbd_ready); end
    step();
    compared++; if (kbd_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL burst_full_hold got %b want 0", kbd_ready); end
    kbd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      compared++; if (fgi !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_fgi_%0d got %b want 1", k, fgi); end
      compared++; if (inpr_out !== 8'h41 + 8'(k)) begin mismatched++; $display("[TB] FAIL drain_inpr_%0d got %h want %h", k, inpr_out, 8'h41 + 8'(k)); end
      inp_exec = 1'b1;
      step();
      inp_exec = 1'b0;
      compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_gap_%0d got %b want 0", k, fgi); end
      step();
    end
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_empty_fgi got %b want 0", fgi); end
    compared++; if (kbd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_ready got %b want 1", kbd_ready); end
  endtask

  task automatic test_output_timing();
    prn_ready = 1'b1; outr_in = 8'h5A; out_exec = 1'b1;
    step();
    out_exec = 1'b0;
    compared++; if (fgo !== 1'b0) begin mismatched++; $display("[TB] FAIL out_fgo_low got %b want 0", fgo); end
    compared++; if (prn_valid0 !== 1'b1) begin mismatched++; $display("[TB] FAIL out0_valid got %b want 1", prn_valid0); end
    compared++; if (prn_data0 !== 8'h5A) begin mismatched++; $display("[TB] FAIL out0_data got %h want 5a", prn_data0); end
    for (int c = 1; c < 8; c++) begin
      compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL out_early_valid_%0d got %b want 0", c, prn_valid); end
      step();
      if (c == 1) begin
        compared++; if (fgo0 !== 1'b1) begin mismatched++; $display("[TB] FAIL out0_fgo got %b want 1", fgo0); end
      end
    end
    compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL out_valid_before_8 got %b want 0", prn_valid); end
    step();
    compared++; if (prn_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL out_valid_at_8 got %b want 1", prn_valid); end
    compared++; if (prn_data !== 8'h5A) begin mismatched++; $display("[TB] FAIL out_data got %h want 5a", prn_data); end
    compared++; if (fgo !== 1'b0) begin mismatched++; $display("[TB] FAIL out_fgo_in_send got %b want 0", fgo); end
    step();
    compared++; if (fgo !== 1'b1) begin mismatched++; $display("[TB] FAIL out_fgo_back got %b want 1", fgo); end
    compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL out_valid_drop got %b want 0", prn_valid); end
  endtask

  task automatic test_back_pressure();
    prn_ready = 1'b0; outr_in = 8'h77; out_exec = 1'b1;
    step();
    out_exec = 1'b0; outr_in = 8'h00;
    repeat (8) step();
    for (int s = 0; s < 5; s++) begin
      compared++; if (prn_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid_%0d got %b want 1", s, prn_valid); end
      compared++; if (prn_data !== 8'h77) begin mismatched++; $display("[TB] FAIL bp_data_%0d got %h want 77", s, prn_data); end
      compared++; if (fgo !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_fgo_%0d got %b want 0", s, fgo); end
      step();
    end
    prn_ready = 1'b1;
    step();
    compared++; if (fgo !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_fgo got %b want 1", fgo); end
    compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release_valid got %b want 0", prn_valid); end
  endtask

  task automatic test_inp_overrun();
    compared++; if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL inp_ovr_pre got %b want 0", overrun); end
    inp_exec = 1'b1;
    step();
    inp_exec = 1'b0;
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL inp_ovr_set got %b want 1", overrun); end
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL inp_ovr_fgi got %b want 0", fgi); end
    compared++; if (inpr_out !== 8'h45) begin mismatched++; $display("[TB] FAIL inp_ovr_inpr got %h want 45", inpr_out); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    kbd_data = 8'h52; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    step();
    compared++; if (fgi !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_fgi_pre got %b want 1", fgi); end
    prn_ready = 1'b0; outr_in = 8'h66; out_exec = 1'b1;
    step();
    out_exec = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (prn_valid === 1'b1) seen = 1;
      else step();
    end
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL ar_wait_send got 0 want 1 (timeout)"); end
    #3;
    reset_n = 1'b0;
    #1;
    compared++; if (fgo !== 1'b1)      begin mismatched++; $display("[TB] FAIL ar_fgo got %b want 1", fgo); end
    compared++; if (fgi !== 1'b0)      begin mismatched++; $display("[TB] FAIL ar_fgi got %b want 0", fgi); end
    compared++; if (prn_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_prn_valid got %b want 0", prn_valid); end
    compared++; if (kbd_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_kbd_ready got %b want 1", kbd_ready); end
    compared++; if (prn_data !== 8'h00) begin mismatched++; $display("[TB] FAIL ar_prn_data got %h want 00", prn_data); end
    compared++; if (inpr_out !== 8'h00) begin mismatched++; $display("[TB] FAIL ar_inpr got %h want 00", inpr_out); end
    compared++; if (overrun !== 1'b0)  begin mismatched++; $display("[TB] FAIL ar_overrun got %b want 0", overrun); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    prn_ready = 1'b1;
    step();
  endtask

  task automatic test_out_overrun();
    prn_ready = 1'b0; outr_in = 8'h11; out_exec = 1'b1;
    step();
    out_exec = 1'b0;
    step();
    outr_in = 8'h33; out_exec = 1'b1;
    step();
    out_exec = 1'b0;
    compared++; if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL out_ovr_set got %b want 1", overrun); end
    compared++; if (fgo !== 1'b0) begin mismatched++; $display("[TB] FAIL out_ovr_fgo got %b want 0", fgo); end
    repeat (6) step();
    compared++; if (prn_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL out_ovr_valid got %b want 1", prn_valid); end
    compared++; if (prn_data !== 8'h11) begin mismatched++; $display("[TB] FAIL out_ovr_data got %h want 11", prn_data); end
    prn_ready = 1'b1;
    step();
    compared++; if (fgo !== 1'b1) begin mismatched++; $display("[TB] FAIL out_ovr_fgo_back got %b want 1", fgo); end
  endtask

  task automatic test_simultaneous();
    kbd_data = 8'h30; kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    step();
    compared++; if (inpr_out !== 8'h30) begin mismatched++; $display("[TB] FAIL sim_inpr got %h want 30", inpr_out); end
    inp_exec = 1'b1; out_exec = 1'b1; outr_in = 8'h39; prn_ready = 1'b1;
    step();
    inp_exec = 1'b0; out_exec = 1'b0;
    compared++; if (fgi !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_fgi got %b want 0", fgi); end
    compared++; if (fgo !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_fgo got %b want 0", fgo); end
    repeat (8) step();
    compared++; if (prn_data !== 8'h39) begin mismatched++; $display("[TB] FAIL sim_prn_data got %h want 39", prn_data); end
    step();
    compared++; if (fgo !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_fgo_back got %b want 1", fgo); end
  endtask

  // Scenario sequence followed by the one summary line.
  initial begin
    test_reset();
    test_single_input();
    test_input_burst();
    test_output_timing();
    test_back_pressure();
    test_inp_overrun();
    test_async_reset();
    test_out_overrun();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/io_terminal.md
Name: io_terminal

Overview:
Peripheral-side partner of the basic computer's I/O instructions: it is the device end of the INPR/FGI and OUTR/FGO handshake.
- Input path: buffers characters from an external keyboard stream, presents them on INPR and raises FGI; the CPU's INP clears FGI.
- Output path: the CPU's OUT clears FGO and loads OUTR. The terminal "prints" the character after a programmable delay, hands it to an external printer stream and sets FGO again.
- Sits beside the datapath and control unit; fgi/fgo feed the control unit's interrupt and skip logic (SKI/SKO).

Parameters:
IN_DEPTH, 4, keyboard buffer depth in characters (power of two, >=2)
OUT_DELAY, 8, print latency in clk cycles between OUT and offering the char to the printer (0 allowed)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
kbd_data  in  8  character from keyboard source
kbd_valid  in  1  kbd_data valid
kbd_ready  out  1  buffer can accept (high when buffer not full)
inpr_out  out  8  INPR register contents to datapath
fgi  out  1  input flag: inpr_out holds an unread char
inp_exec  in  1  one-cycle pulse: CPU executes INP this cycle
outr_in  in  8  AC[7:0] being written to OUTR
out_exec  in  1  one-cycle pulse: CPU executes OUT this cycle
fgo  out  1  output flag: device ready for next char
prn_data  out  8  character to printer sink
prn_valid  out  1  prn_data valid
prn_ready  in  1  printer accepts
overrun  out  1  sticky: OUT while fgo=0, or INP while fgi=0

Behaviour:
- Reset (async, reset_n=0): buffer empty, kbd_ready=1, inpr_out=0, fgi=0, fgo=1, prn_valid=0, prn_data=0, overrun=0, output FSM=IDLE. Reset mid-print discards the char.
- Keyboard push: push occurs on an edge where kbd_valid & kbd_ready. Data is stable while kbd_valid=1 and ready=0.
- FIFO push and pop in the same edge: count is unchanged. When full, kbd_ready=0 and nothing is pushed.
- INPR load: on an edge where fgi=0 and buffer non-empty, pop the head into inpr_out and set fgi=1.
  - Latency from push into an empty buffer to fgi=1 is 2 edges (push, then load).
- INP: an edge with inp_exec & fgi clears fgi. inpr_out holds its value until the next load.
  - The next load happens no earlier than the following edge, so fgi is low for >=1 cycle between chars.
- inp_exec with fgi=0: no state change, overrun<=1.
- Output FSM:
  - IDLE (fgo=1): on out_exec, latch outr_in into prn_data and set fgo<=0. Go to DELAY, or to SEND if OUT_DELAY=0.
  - DELAY: counter loads OUT_DELAY-1 and decrements each cycle; at 0, go to SEND.
  - SEND: prn_valid=1 and prn_data stable until the edge with prn_ready. On that edge: prn_valid<=0, fgo<=1, go to IDLE.
- out_exec while fgo=0 (any non-IDLE state): ignored, latched char unchanged, overrun<=1.
- Total OUT-to-fgo latency = 1 + OUT_DELAY + printer stall cycles + 1.
- Input and output paths are independent; simultaneous inp_exec and out_exec are both honoured.
- overrun clears only on reset.

Decomposition:
- Shared package io_pkg: CHAR_W=8, output state enum {IDLE, DELAY, SEND}, default IN_DEPTH/OUT_DELAY constants.
- One sub-module, io_fifo (parameterised width/depth, push/pop/full/empty/count), used for the keyboard buffer.
- Output FSM and counter stay in io_terminal.

Test Plan:
- Reset: assert reset_n=0 mid-SEND with fgi=1 -> all outputs immediately at reset values (fgo=1, fgi=0, prn_valid=0, kbd_ready=1).
- Single input char: push 0x44 into an empty buffer -> fgi=1 and inpr_out=0x44 two edges later. Pulse inp_exec -> fgi=0 next edge and inpr_out stays 0x44.
- Input burst: push 0x41..0x46 back-to-back with IN_DEPTH=4 and no INP -> kbd_ready drops after the buffer fills (one char already in INPR, four buffered). Drain with repeated INP -> 0x41..0x45 delivered in order, each with an fgi low gap of >=1 cycle.
- Output timing: OUT_DELAY=8, out_exec with outr_in=0x5A, prn_ready=1 -> fgo=0 next edge, prn_valid rises 8 cycles later with prn_data=0x5A, fgo=1 on the following edge. Repeat with OUT_DELAY=0 -> prn_valid the cycle after out_exec.
- Back-pressure: prn_ready=0 for 5 cycles in SEND -> prn_valid and prn_data stay stable and fgo stays 0; on prn_ready=1 -> fgo=1 next edge.
- Overrun: second out_exec with outr_in=0x33 while fgo=0 -> printed char remains the first one and overrun=1. inp_exec with fgi=0 -> overrun=1 and no flag change.
